// File: rtl/qspim_host.sv
// Quad-SPI host: one command/address/data transaction per request, mode-0 clocking.
// Every nibble is shifted MSB-first; reads add an optional dummy phase and a bus turnaround.
module qspim_host #(
    parameter int CLK_DIV   = 2,
    parameter int DUMMY_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  cmd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        sclk,
    output logic        ssn,
    output logic [3:0]  sdout,
    output logic        sdout_oen,
    input  logic [3:0]  sdin
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CS_SETUP = 4'd1,
        CMD      = 4'd2,
        ADDR     = 4'd3,
        DUMMY    = 4'd4,
        WDATA    = 4'd5,
        RDATA    = 4'd6,
        CS_HOLD  = 4'd7,
        CS_GAP   = 4'd8
    } state_t;

    localparam int          DIV_LAST_I   = CLK_DIV - 1;
    localparam logic [7:0]  DIV_LAST     = DIV_LAST_I[7:0];
    localparam int          DUMMY_LAST_I = (DUMMY_CYC > 0) ? (DUMMY_CYC - 1) : 0;
    localparam logic [3:0]  DUMMY_LAST   = DUMMY_LAST_I[3:0];

    state_t      state_r;
    state_t      state_nx;
    logic [7:0]  div_cnt_r;
    logic [7:0]  div_cnt_nx;
    logic [3:0]  nib_cnt_r;
    logic [3:0]  nib_cnt_nx;
    logic        we_r;
    logic        we_nx;
    logic [67:0] tx_r;
    logic [67:0] tx_nx;
    logic [31:0] rx_r;
    logic [31:0] rx_nx;
    logic        sclk_r;
    logic        sclk_nx;
    logic        ssn_r;
    logic        ssn_nx;
    logic [3:0]  sdout_r;
    logic [3:0]  sdout_nx;
    logic        oen_r;
    logic        oen_nx;
    logic        ack_r;
    logic        ack_nx;
    logic        busy_r;
    logic        busy_nx;
    logic [31:0] rdata_r;
    logic [31:0] rdata_nx;

    logic        tick_s;
    logic        shift_phase_s;
    logic        rise_s;
    logic        fall_s;
    logic        accept_s;
    logic [3:0]  phase_last_s;
    logic        at_last_s;

    assign tick_s        = (state_r != IDLE) && (div_cnt_r == DIV_LAST);
    assign shift_phase_s = (state_r == CMD) || (state_r == ADDR) || (state_r == DUMMY) ||
                           (state_r == WDATA) || (state_r == RDATA);
    assign rise_s        = tick_s && shift_phase_s && !sclk_r;
    assign fall_s        = tick_s && shift_phase_s && sclk_r;
    // The ack cycle itself is IDLE but must not accept, so a held request waits one cycle.
    assign accept_s      = (state_r == IDLE) && req_i && !ack_r;
    assign at_last_s     = (nib_cnt_r == phase_last_s);

    // Index of the final sclk cycle (or half-period for CS_GAP) of the current step
    always_comb begin
        phase_last_s = 4'd0;
        case (state_r)
            CMD:           phase_last_s = 4'd1;
            ADDR:          phase_last_s = 4'd7;
            DUMMY:         phase_last_s = DUMMY_LAST;
            WDATA, RDATA:  phase_last_s = 4'd7;
            CS_GAP:        phase_last_s = 4'd1;
            default:       phase_last_s = 4'd0;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; data phases end on the falling edge of their last sclk cycle
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx = CS_SETUP;
                else          state_nx = IDLE;
            end
            CS_SETUP: begin
                if (tick_s) state_nx = CMD;
                else        state_nx = CS_SETUP;
            end
            CMD: begin
                if (fall_s && at_last_s) state_nx = ADDR;
                else                     state_nx = CMD;
            end
            ADDR: begin
                if (fall_s && at_last_s) begin
                    if (we_r)                state_nx = WDATA;
                    else if (DUMMY_CYC == 0) state_nx = RDATA;
                    else                     state_nx = DUMMY;
                end else begin
                    state_nx = ADDR;
                end
            end
            DUMMY: begin
                if (fall_s && at_last_s) state_nx = RDATA;
                else                     state_nx = DUMMY;
            end
            WDATA, RDATA: begin
                if (fall_s && at_last_s) state_nx = CS_HOLD;
                else                     state_nx = state_r;
            end
            CS_HOLD: begin
                if (tick_s) state_nx = CS_GAP;
                else        state_nx = CS_HOLD;
            end
            CS_GAP: begin
                if (tick_s && at_last_s) state_nx = IDLE;
                else                     state_nx = CS_GAP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the counters, shifters and pad/handshake registers
    always_comb begin
        we_nx      = we_r;
        tx_nx      = tx_r;
        rx_nx      = rx_r;
        sclk_nx    = sclk_r;
        ssn_nx     = ssn_r;
        sdout_nx   = sdout_r;
        oen_nx     = oen_r;
        ack_nx     = 1'b0;
        busy_nx    = busy_r;
        rdata_nx   = rdata_r;
        nib_cnt_nx = nib_cnt_r;

        if ((state_r == IDLE) || tick_s) div_cnt_nx = 8'd0;
        else                             div_cnt_nx = div_cnt_r + 8'd1;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    we_nx      = we_i;
                    tx_nx      = {cmd_i[3:0], addr_i, wdata_i};
                    rx_nx      = 32'h0000_0000;
                    ssn_nx     = 1'b0;
                    oen_nx     = 1'b0;
                    sdout_nx   = cmd_i[7:4];
                    busy_nx    = 1'b1;
                    nib_cnt_nx = 4'd0;
                end else begin
                    busy_nx    = 1'b0;
                end
            end
            CS_SETUP: begin
                if (tick_s) begin
                    sclk_nx    = 1'b1;
                    nib_cnt_nx = 4'd0;
                end else begin
                    sclk_nx    = sclk_r;
                end
            end
            CMD, ADDR, DUMMY, WDATA, RDATA: begin
                if (rise_s) begin
                    sclk_nx = 1'b1;
                    if (state_r == RDATA) rx_nx = {rx_r[27:0], sdin};
                    else                  rx_nx = rx_r;
                end else if (fall_s) begin
                    sclk_nx = 1'b0;
                    if (at_last_s) nib_cnt_nx = 4'd0;
                    else           nib_cnt_nx = nib_cnt_r + 4'd1;
                    // Read turnaround: release the pads as the address leaves the wire.
                    if ((state_r == ADDR) && at_last_s && !we_r) begin
                        oen_nx   = 1'b1;
                        sdout_nx = 4'h0;
                    end else if ((state_r == CMD) || (state_r == ADDR) ||
                                 ((state_r == WDATA) && !at_last_s)) begin
                        sdout_nx = tx_r[67:64];
                        tx_nx    = {tx_r[63:0], 4'h0};
                    end else begin
                        sdout_nx = sdout_r;
                    end
                end else begin
                    sclk_nx = sclk_r;
                end
            end
            CS_HOLD: begin
                if (tick_s) begin
                    ssn_nx     = 1'b1;
                    oen_nx     = 1'b1;
                    nib_cnt_nx = 4'd0;
                end else begin
                    ssn_nx     = ssn_r;
                end
            end
            CS_GAP: begin
                if (tick_s) begin
                    if (at_last_s) begin
                        ack_nx     = 1'b1;
                        busy_nx    = 1'b0;
                        nib_cnt_nx = 4'd0;
                        if (!we_r) rdata_nx = rx_r;
                        else       rdata_nx = rdata_r;
                    end else begin
                        nib_cnt_nx = nib_cnt_r + 4'd1;
                    end
                end else begin
                    nib_cnt_nx = nib_cnt_r;
                end
            end
            default: begin
                ack_nx = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= 8'd0;
            nib_cnt_r <= 4'd0;
            we_r      <= 1'b0;
            tx_r      <= 68'h0;
            rx_r      <= 32'h0000_0000;
            sclk_r    <= 1'b0;
            ssn_r     <= 1'b1;
            sdout_r   <= 4'h0;
            oen_r     <= 1'b1;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            div_cnt_r <= div_cnt_nx;
            nib_cnt_r <= nib_cnt_nx;
            we_r      <= we_nx;
            tx_r      <= tx_nx;
            rx_r      <= rx_nx;
            sclk_r    <= sclk_nx;
            ssn_r     <= ssn_nx;
            sdout_r   <= sdout_nx;
            oen_r     <= oen_nx;
            ack_r     <= ack_nx;
            busy_r    <= busy_nx;
            rdata_r   <= rdata_nx;
        end
    end

    assign ack_o     = ack_r;
    assign rdata_o   = rdata_r;
    assign busy_o    = busy_r;
    assign sclk      = sclk_r;
    assign ssn       = ssn_r;
    assign sdout     = sdout_r;
    assign sdout_oen = oen_r;

endmodule
